enc_gen_multi: RTL

ENC_GEN_MULTI -- requirements
Module: enc_gen_multi

---
 rtl/enc_gen_pkg.sv | 18 +
 rtl/enc_gen_ch.sv | 98 +++++++++
 rtl/enc_gen_multi.sv | 42 ++++
 3 files changed

// File: rtl/enc_gen_pkg.sv
// enc_gen_pkg: quadrature state encoding, next-state helper and parameter range limits
package enc_gen_pkg;
  localparam int NUM_CH_MIN = 1;
  localparam int NUM_CH_MAX = 8;
  localparam int CNT_W_MIN  = 8;
  localparam int CNT_W_MAX  = 32;
  // encoded as {A,B} so the quadrature outputs come straight from the state flops
  typedef enum logic [1:0] {
    S1 = 2'b00,
    S2 = 2'b10,
    S3 = 2'b11,
    S4 = 2'b01
  } qstate_t;
  function automatic qstate_t q_next(qstate_t s, logic fwd);
    return fwd ? ((s == S1) ? S2 : (s == S2) ? S3 : (s == S3) ? S4 : S1)
               : ((s == S1) ? S4 : (s == S4) ? S3 : (s == S3) ? S2 : S1);
  endfunction
endpackage

// File: rtl/enc_gen_ch.sv
// enc_gen_ch: one quadrature encoder channel with index pulse and stop-after limit.
// The signed position counter exists only when ENC_GEN_POS_EN is defined.
module enc_gen_ch
  import enc_gen_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             xclk,
  input  logic             reset,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] index_period,
  input  logic [CNT_W-1:0] stop_after,
  input  logic             dir,
  input  logic             load,
  input  logic             manual_stop,
  output logic             enca,
  output logic             encb,
  output logic             enci,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] pos
);
  localparam logic [CNT_W-1:0] one = CNT_W'(1);
  logic [CNT_W-1:0] per_s, idx_per_s, stop_s;
  logic [CNT_W-1:0] psc, psc_nxt, idx_cnt, idx_nxt, steps, steps_nxt;
  logic             dir_s, armed, tick, done_nxt, enci_nxt;
  qstate_t          st, st_nxt;
  assign running = armed & ~done & ~manual_stop;
  assign tick    = running & ~load & (psc == per_s);
  assign enca    = st[1];
  assign encb    = st[0];
  always_ff @(posedge xclk or negedge reset) begin
    if (!reset) begin
      per_s     <= '0;
      idx_per_s <= '0;
      stop_s    <= '0;
      dir_s     <= 1'b0;
      armed     <= 1'b0;
      st        <= S1;
      idx_cnt   <= '0;
      psc       <= '0;
      steps     <= '0;
      done      <= 1'b0;
      enci      <= 1'b0;
    end else begin
      if (load) begin
        per_s     <= period;
        idx_per_s <= index_period;
        stop_s    <= stop_after;
        dir_s     <= dir;
        armed     <= 1'b1;
      end
      st      <= st_nxt;
      idx_cnt <= idx_nxt;
      psc     <= psc_nxt;
      steps   <= steps_nxt;
      done    <= done_nxt;
      enci    <= enci_nxt;
    end
  end
  // index counter wraps on A rising going forward and on A falling going backward,
  // so the same physical A-high interval carries the index in both directions
  always_comb begin
    st_nxt    = st;
    idx_nxt   = idx_cnt;
    psc_nxt   = psc;
    steps_nxt = steps;
    done_nxt  = done;
    if (load) begin
      psc_nxt   = '0;
      steps_nxt = '0;
      done_nxt  = 1'b0;
      idx_nxt   = (idx_cnt > index_period) ? '0 : idx_cnt;
    end else if (running) begin
      psc_nxt = tick ? '0 : psc + one;
      if (tick) begin
        st_nxt = q_next(st, dir_s);
        if (dir_s && !st[1] && st_nxt[1])
          idx_nxt = (idx_cnt == idx_per_s) ? '0 : idx_cnt + one;
        if (!dir_s && st[1] && !st_nxt[1])
          idx_nxt = (idx_cnt == '0) ? idx_per_s : idx_cnt - one;
        if (stop_s != '0) begin
          steps_nxt = steps + one;
          done_nxt  = (steps_nxt == stop_s);
        end
      end
    end
    enci_nxt = (idx_nxt == '0) && st_nxt[1];
  end
`ifdef ENC_GEN_POS_EN
  always_ff @(posedge xclk or negedge reset) begin
    if (!reset) pos <= '0;
    else if (tick) pos <= dir_s ? pos + one : pos - one;
  end
`else
  assign pos = '0;
`endif
endmodule

// File: rtl/enc_gen_multi.sv
// enc_gen_multi: NUM_CH independent quadrature encoder generators on one clock.
// Define ENC_GEN_POS_EN to add a signed position counter per channel.
module enc_gen_multi #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32
) (
  input  logic                    xclk,
  input  logic                    reset,
  input  logic [NUM_CH*CNT_W-1:0] period,
  input  logic [NUM_CH*CNT_W-1:0] index_period,
  input  logic [NUM_CH*CNT_W-1:0] stop_after,
  input  logic [NUM_CH-1:0]       dir,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH-1:0]       manual_stop,
  output logic [NUM_CH-1:0]       enca,
  output logic [NUM_CH-1:0]       encb,
  output logic [NUM_CH-1:0]       enci,
  output logic [NUM_CH-1:0]       running,
  output logic [NUM_CH-1:0]       done,
  output logic [NUM_CH*CNT_W-1:0] pos
);
  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      enc_gen_ch #(.CNT_W(CNT_W)) u_ch (
        .xclk         (xclk),
        .reset        (reset),
        .period       (period[i*CNT_W +: CNT_W]),
        .index_period (index_period[i*CNT_W +: CNT_W]),
        .stop_after   (stop_after[i*CNT_W +: CNT_W]),
        .dir          (dir[i]),
        .load         (load[i]),
        .manual_stop  (manual_stop[i]),
        .enca         (enca[i]),
        .encb         (encb[i]),
        .enci         (enci[i]),
        .running      (running[i]),
        .done         (done[i]),
        .pos          (pos[i*CNT_W +: CNT_W])
      );
    end
  endgenerate
endmodule
